aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, asynchronous, active-low.
REQ-003: start  input  1  one-cycle pulse; begins a full 10-round schedule; sampled only in IDLE.
REQ-004: key_in  input  8  cipher key byte, stream order byte0..byte15 (FIPS-197 column-major).
REQ-005: key_valid  input  1  qualifies key_in during LOAD.
REQ-006: exp_din  output  8  previous-round key byte to the one-round expansion engine.
REQ-007: exp_load  output  1  qualifies exp_din; high for exactly 16 consecutive cycles per round.
REQ-008: exp_rcon  output  8  round constant, held stable from first exp_load until the round's last exp_valid.
REQ-009: exp_dout  input  8  expanded key byte returned by engine, byte0..byte15 order.
REQ-010: exp_valid  input  1  qualifies exp_dout.
REQ-011: rk_raddr  input  8  round-key read address {round[3:0], byte[3:0]}; round 0..10.
REQ-012: rk_rdata  output  8  registered read data, 1-cycle latency.
REQ-013: busy  output  1  high in any state except IDLE.
REQ-014: done  output  1  one-cycle pulse when round 10 stored.
REQ-015: rk_ready  output  1  high from done until next accepted start.
REQ-016: err  output  1  sticky watchdog error flag (see Configuration).

Function
REQ-017: States IDLE, LOAD, ISSUE, COLLECT, DONE, ERR; ERR exists only with the Configuration macro.
REQ-018: IDLE -> LOAD on start; rk_ready cleared, round r=0, byte counter 0; start in any other state ignored.
REQ-019: LOAD: each key_valid cycle writes key_in to rk_mem[0][cnt], cnt++; after 16th byte -> ISSUE, cnt=0.
REQ-020: ISSUE: 16 cycles, exp_load=1, exp_din=rk_mem[r][cnt]; then -> COLLECT, cnt=0.
REQ-021: exp_rcon = Rcon(r+1): 01,02,04,08,10,20,40,80,1B,36 for r=0..9.
REQ-022: COLLECT: each exp_valid writes exp_dout to rk_mem[r+1][cnt], cnt++; after 16th, r==9 -> DONE else r++ -> ISSUE.
REQ-023: exp_valid outside COLLECT ignored; exp_valid during ISSUE not captured.
REQ-024: DONE: done=1 and rk_ready=1 for one cycle, then -> IDLE.
REQ-025: rk_mem is 176x8; reads allowed in every state; reading an unwritten round returns stale contents.
REQ-026: rk_raddr with round>10 returns 8'h00.
REQ-027: Counters 4-bit byte, 4-bit round; no wrap beyond limits (state transitions occur first).

Reset
REQ-028: rst_n low asynchronously forces IDLE; busy, done, rk_ready, err, exp_load, exp_din, exp_rcon, rk_rdata = 0; counters = 0.
REQ-029: rk_mem not reset; reset mid-schedule abandons it, rk_ready stays 0 until a later full schedule completes.

Configuration
REQ-030: Macro KEYSCHED_TIMEOUT_EN defined: 8-bit watchdog cleared on entry to COLLECT and on each exp_valid; reaching 255 -> ERR, err=1, busy=1, exit only by reset.
REQ-031: Macro not defined: COLLECT waits indefinitely, no ERR state, err tied 0.

Verification
REQ-032: Reset mid-LOAD (byte 7) -> all outputs 0 next cycle, IDLE, start after reset loads 16 fresh bytes.
REQ-033: Key 2b7e151628aed2a6abf7158809cf4f3c with behavioural engine -> done pulse; round1 bytes a0fafe1788542cb123a339392a6c7605; round10 d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034: Monitor exp_rcon across schedule -> exactly sequence 01..36 per REQ-021, each stable over its round; 160 exp_load cycles total.
REQ-035: start pulsed while busy, stray exp_valid in ISSUE -> no restart, result identical to REQ-033.
REQ-036: rk_raddr=8'hA0 after done -> rk_rdata=8'hd0 one cycle later; rk_raddr=8'hB0 -> 8'h00.
REQ-037: KEYSCHED_TIMEOUT_EN defined, engine silent after 5 bytes -> err=1 after 255 idle cycles, done never asserted.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// Bundled host/engine/readback signals of the AES-128 key-schedule controller.
// master = host side (key source, expansion engine, reader); slave = controller.
interface aes_key_sched_ctrl_if;
    logic       start;
    logic [7:0] key_in;
    logic       key_valid;
    logic [7:0] exp_din;
    logic       exp_load;
    logic [7:0] exp_rcon;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic [7:0] rk_raddr;
    logic [7:0] rk_rdata;
    logic       busy;
    logic       done;
    logic       rk_ready;
    logic       err;
    logic [2:0] state_dbg;

    // Handshakes: key_in counts only in a key_valid cycle, exp_din only while
    // exp_load is high, exp_dout only while exp_valid is high; no backpressure.
    modport master (
        output start, key_in, key_valid, exp_dout, exp_valid, rk_raddr,
        input  exp_din, exp_load, exp_rcon, rk_rdata, busy, done, rk_ready, err, state_dbg
    );
    modport slave (
        input  start, key_in, key_valid, exp_dout, exp_valid, rk_raddr,
        output exp_din, exp_load, exp_rcon, rk_rdata, busy, done, rk_ready, err, state_dbg
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: loads the cipher key, drives an external one-round
// engine ten times and stores all 11 round keys. KEYSCHED_TIMEOUT_EN adds a COLLECT watchdog.
module aes_key_sched_ctrl (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_sched_ctrl_if.slave   bus
);

`ifdef KEYSCHED_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD = 3'd1, S_ISSUE = 3'd2, S_COLLECT = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD = 3'd1, S_ISSUE = 3'd2, S_COLLECT = 3'd3, S_DONE = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rnd_q, rnd_d;
    logic       rk_ready_q, rk_ready_d;
    logic [7:0] rk_rdata_q, rk_rdata_d;
`ifdef KEYSCHED_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
`endif

    // Round r lives at addresses r*16 .. r*16+15, so the read address maps straight through.
    logic [7:0] rk_mem [0:175];
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd0: rcon_of = 8'h01;
            4'd1: rcon_of = 8'h02;
            4'd2: rcon_of = 8'h04;
            4'd3: rcon_of = 8'h08;
            4'd4: rcon_of = 8'h10;
            4'd5: rcon_of = 8'h20;
            4'd6: rcon_of = 8'h40;
            4'd7: rcon_of = 8'h80;
            4'd8: rcon_of = 8'h1b;
            4'd9: rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rnd_q      <= 4'd0;
            rk_ready_q <= 1'b0;
            rk_rdata_q <= 8'h00;
`ifdef KEYSCHED_TIMEOUT_EN
            wdog_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnd_q      <= rnd_d;
            rk_ready_q <= rk_ready_d;
            rk_rdata_q <= rk_rdata_d;
`ifdef KEYSCHED_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) rk_mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        rk_rdata_d = 8'h00;
        if (bus.rk_raddr[7:4] <= 4'd10) rk_rdata_d = rk_mem[bus.rk_raddr];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnd_d      = rnd_q;
        rk_ready_d = rk_ready_q;
        mem_we     = 1'b0;
        mem_waddr  = 8'h00;
        mem_wdata  = 8'h00;
`ifdef KEYSCHED_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    cnt_d      = 4'd0;
                    rnd_d      = 4'd0;
                    rk_ready_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.key_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {4'd0, cnt_q};
                    mem_wdata = bus.key_in;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_ISSUE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_COLLECT;
                    cnt_d   = 4'd0;
`ifdef KEYSCHED_TIMEOUT_EN
                    wdog_d  = 8'h00;
`endif
                end
            end
            S_COLLECT: begin
                if (bus.exp_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {rnd_q + 4'd1, cnt_q};
                    mem_wdata = bus.exp_dout;
                    cnt_d     = cnt_q + 4'd1;
`ifdef KEYSCHED_TIMEOUT_EN
                    wdog_d    = 8'h00;
`endif
                    if (cnt_q == 4'd15) begin
                        cnt_d = 4'd0;
                        if (rnd_q == 4'd9) begin
                            state_d    = S_DONE;
                            rk_ready_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                            rnd_d   = rnd_q + 4'd1;
                        end
                    end
                end
`ifdef KEYSCHED_TIMEOUT_EN
                else if (wdog_q == 8'hff) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
`ifdef KEYSCHED_TIMEOUT_EN
            S_ERR:  state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.rk_ready  = rk_ready_q;
        bus.rk_rdata  = rk_rdata_q;
        bus.exp_load  = (state_q == S_ISSUE);
        bus.exp_din   = 8'h00;
        bus.exp_rcon  = 8'h00;
        bus.state_dbg = state_q;
`ifdef KEYSCHED_TIMEOUT_EN
        bus.err       = (state_q == S_ERR);
`else
        bus.err       = 1'b0;
`endif
        if (state_q == S_ISSUE) bus.exp_din = rk_mem[{rnd_q, cnt_q}];
        // Rcon is tied to the round counter, which only advances after the last capture.
        if (state_q == S_ISSUE || state_q == S_COLLECT) bus.exp_rcon = rcon_of(rnd_q);
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural one-round AES key-expansion engine.
// Watchdog checks depend on KEYSCHED_TIMEOUT_EN matching the RTL build.
module tb_aes_key_sched_ctrl;
    logic clk;
    logic rst_n;
    aes_key_sched_ctrl_if ifc ();

    aes_key_sched_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboard: round constants the engine must see, one per round, in order.
    logic [7:0] exp_q[$];

    // Engine controls (written by main) and statistics (written by engine).
    int   eng_limit     = 1000000;
    bit   stray_mode    = 0;
    int   eng_sent      = 0;
    int   loads_total   = 0;
    int   rcon_unstable = 0;
    int   n_done        = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural expansion engine ----------------
    initial begin : engine
        logic [7:0] prev [16];
        logic [7:0] nxt  [16];
        logic [7:0] t [4];
        logic [7:0] round_rcon;
        int  ld_idx, out_idx, pending;
        bit  gap;
        ld_idx = 0; out_idx = 0; pending = 0; gap = 0; round_rcon = 8'h00;
        ifc.exp_valid = 1'b0;
        ifc.exp_dout  = 8'h00;
        forever begin
            @(negedge clk);
            ifc.exp_valid = 1'b0;
            ifc.exp_dout  = 8'h00;
            if (!rst_n) begin
                ld_idx  = 0;
                pending = 0;
            end else if (ifc.exp_load) begin
                if (ld_idx == 0) begin
                    round_rcon = ifc.exp_rcon;
                    if (exp_q.size() == 0) chk("rcon_extra", {120'd0, ifc.exp_rcon}, 128'hffff);
                    else chk("rcon", {120'd0, ifc.exp_rcon}, {120'd0, exp_q.pop_front()});
                end else if (ifc.exp_rcon !== round_rcon) begin
                    rcon_unstable++;
                end
                prev[ld_idx] = ifc.exp_din;
                loads_total++;
                if (stray_mode && ld_idx == 4) begin
                    ifc.exp_valid = 1'b1;
                    ifc.exp_dout  = 8'hee;
                end
                ld_idx++;
                if (ld_idx == 16) begin
                    t[0] = SBOX[prev[13]] ^ round_rcon;
                    t[1] = SBOX[prev[14]];
                    t[2] = SBOX[prev[15]];
                    t[3] = SBOX[prev[12]];
                    for (int j = 0; j < 4; j++) nxt[j] = prev[j] ^ t[j];
                    for (int k = 4; k < 16; k++) nxt[k] = prev[k] ^ nxt[k-4];
                    ld_idx = 0; out_idx = 0; pending = 16; gap = 0;
                end
            end else if (pending > 0 && eng_sent < eng_limit) begin
                if (ifc.exp_rcon !== round_rcon) rcon_unstable++;
                if (gap) begin
                    gap = 0;
                end else begin
                    ifc.exp_valid = 1'b1;
                    ifc.exp_dout  = nxt[out_idx];
                    out_idx++;
                    pending--;
                    eng_sent++;
                    gap = (out_idx % 3 == 0);
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && ifc.done) n_done++;

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk); ifc.start = 1'b1;
        @(negedge clk); ifc.start = 1'b0;
    endtask

    task automatic load_bytes(input logic [127:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 5) begin
                ifc.key_valid = 1'b0;
                @(negedge clk);
            end
            ifc.key_valid = 1'b1;
            ifc.key_in    = key[127-8*i -: 8];
        end
        @(negedge clk);
        ifc.key_valid = 1'b0;
        ifc.key_in    = 8'h00;
    endtask

    task automatic push_rcons();
        for (int i = 0; i < 10; i++) exp_q.push_back(RCON_TBL[i]);
    endtask

    // Waits for the done pulse; optionally pulses start once mid-schedule.
    task automatic wait_done(input string tag, input bit poke_start);
        bit seen;
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (ifc.done) begin
                seen = 1;
                chk({tag, "_done_flags"}, {126'd0, ifc.rk_ready, ifc.busy}, 128'h3);
            end else if (poke_start && c == 60) begin
                ifc.start = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
        end
        ifc.start = 1'b0;
        chk({tag, "_done_seen"}, {127'd0, seen}, 128'h1);
        @(negedge clk);
        chk({tag, "_after_done"}, {125'd0, ifc.done, ifc.busy, ifc.rk_ready}, 128'h1);
    endtask

    task automatic read_byte(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk);
        ifc.rk_raddr = addr;
        @(posedge clk);
        #1 data = ifc.rk_rdata;
    endtask

    task automatic read_round(input int r, output logic [127:0] v);
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            read_byte({r[3:0], i[3:0]}, b);
            v[127-8*i -: 8] = b;
        end
    endtask

    task automatic check_rst_outs(input string tag);
        chk(tag, {99'd0, ifc.busy, ifc.done, ifc.rk_ready, ifc.err, ifc.exp_load,
                  ifc.exp_din, ifc.exp_rcon, ifc.rk_rdata}, 128'd0);
        chk({tag, "_state"}, {125'd0, ifc.state_dbg}, 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [127:0] v;
        logic [7:0]   b;
        int base_loads, base_unst, base_sent, base_done, n;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.key_in = 8'h00; ifc.key_valid = 1'b0; ifc.rk_raddr = 8'h00;
        #2 check_rst_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset during LOAD after seven junk bytes, then a fresh full schedule.
        pulse_start();
        load_bytes(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 7);
        chk("midload_busy", {127'd0, ifc.busy}, 128'h1);
        rst_n = 1'b0;
        #1 check_rst_outs("midload_rst");
        @(negedge clk);
        rst_n = 1'b1;

        push_rcons();
        base_loads = loads_total;
        base_unst  = rcon_unstable;
        pulse_start();
        load_bytes(KEY, 16);
        wait_done("run1", 1'b0);
        chk("rcon_all_used", {96'd0, 32'(exp_q.size())}, 128'd0);
        chk("rcon_stable", {96'd0, 32'(rcon_unstable - base_unst)}, 128'd0);
        chk("load_cycles", {96'd0, 32'(loads_total - base_loads)}, 128'd160);
        read_round(0, v); chk("run1_round0", v, KEY);
        read_round(1, v); chk("run1_round1", v, RK1);
        read_round(10, v); chk("run1_round10", v, RK10);
        read_byte(8'ha0, b); chk("rd_a0", {120'd0, b}, 128'hd0);
        read_byte(8'hb0, b); chk("rd_b0", {120'd0, b}, 128'h00);
        read_byte(8'hff, b); chk("rd_ff", {120'd0, b}, 128'h00);

        // Start while busy and a stray exp_valid during ISSUE must not disturb the run.
        exp_q.delete();
        push_rcons();
        stray_mode = 1;
        base_done  = n_done;
        pulse_start();
        chk("rdy_cleared", {126'd0, ifc.rk_ready, ifc.busy}, 128'h1);
        load_bytes(KEY, 16);
        wait_done("run2", 1'b1);
        stray_mode = 0;
        chk("run2_one_done", {96'd0, 32'(n_done - base_done)}, 128'd1);
        read_round(1, v); chk("run2_round1", v, RK1);
        read_round(10, v); chk("run2_round10", v, RK10);

        // Engine goes silent after five bytes of round 1.
        exp_q.delete();
        push_rcons();
        base_sent = eng_sent;
        base_done = n_done;
        eng_limit = base_sent + 5;
        pulse_start();
        load_bytes(KEY, 16);
        n = 0;
        while (eng_sent != base_sent + 5 && n < 500) begin
            @(negedge clk);
            #2 n++;
        end
        chk("silent_reached", {127'd0, (eng_sent == base_sent + 5)}, 128'h1);
        @(posedge clk);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1 n++;
            if (ifc.err) break;
        end
`ifdef KEYSCHED_TIMEOUT_EN
        chk("wdog_cycles", {96'd0, 32'(n)}, 128'd256);
        chk("err_flags", {126'd0, ifc.err, ifc.busy}, 128'h3);
        repeat (5) @(posedge clk);
        #1 chk("err_sticky", {127'd0, ifc.err}, 128'h1);
`else
        chk("no_wdog", {126'd0, ifc.err, ifc.busy}, 128'h1);
        chk("still_collect", {125'd0, ifc.state_dbg}, 128'd3);
`endif
        chk("silent_no_done", {96'd0, 32'(n_done - base_done)}, 128'd0);
        chk("silent_not_ready", {127'd0, ifc.rk_ready}, 128'h0);

        @(negedge clk);
        rst_n = 1'b0;
        #1 check_rst_outs("final_rst");
        exp_q.delete();
        eng_limit = 1000000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {126'd0, ifc.busy, ifc.rk_ready}, 128'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
